// File: rtl/branch_predictor.sv
// Fetch-stage 2-bit branch predictor with a direct-mapped BTB.
// Lookup is combinational on pc_IF; training happens in EX on pc_EX.
module branch_predictor #(
   parameter int unsigned ENTRIES = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] pc_IF,
   output logic        pred_taken_o,
   output logic [31:0] pred_pc_o,
   input  logic        update_en_i,
   input  logic [31:0] pc_EX,
   input  logic        taken_EX,
   input  logic [31:0] target_EX,
   input  logic        mispredict_i,
   output logic [31:0] br_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [31:0]       target_d [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];
   logic [1:0]        ctr_d    [ENTRIES];
   logic [31:0]       br_cnt_q, br_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0]  rd_idx_c, wr_idx_c;
   logic [TAG_W-1:0]  rd_tag_c, wr_tag_c;
   logic              rd_hit_c, wr_hit_c;
   logic              unused_c;

   assign rd_idx_c = pc_IF[IDX_W+1:2];
   assign rd_tag_c = pc_IF[31:IDX_W+2];
   assign wr_idx_c = pc_EX[IDX_W+1:2];
   assign wr_tag_c = pc_EX[31:IDX_W+2];
   assign unused_c = ^{pc_IF[1:0], pc_EX[1:0]};

   // Lookup always sees pre-update contents; no write-to-read bypass.
   always_comb begin
      rd_hit_c     = valid_q[rd_idx_c] && (tag_q[rd_idx_c] == rd_tag_c);
      pred_taken_o = rd_hit_c && ctr_q[rd_idx_c][1];
      pred_pc_o    = pred_taken_o ? target_q[rd_idx_c] : pc_IF + 32'd4;
   end

   // Training: hits move the counter, taken misses allocate, not-taken misses are dropped.
   always_comb begin
      valid_d    = valid_q;
      tag_d      = tag_q;
      target_d   = target_q;
      ctr_d      = ctr_q;
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      wr_hit_c   = valid_q[wr_idx_c] && (tag_q[wr_idx_c] == wr_tag_c);
      if (update_en_i) begin
         br_cnt_d = br_cnt_q + 32'd1;
         if (mispredict_i) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
         end
         if (wr_hit_c) begin
            if (taken_EX) begin
               if (ctr_q[wr_idx_c] != 2'b11) begin
                  ctr_d[wr_idx_c] = ctr_q[wr_idx_c] + 2'd1;
               end
               target_d[wr_idx_c] = target_EX;
            end else if (ctr_q[wr_idx_c] != 2'b00) begin
               ctr_d[wr_idx_c] = ctr_q[wr_idx_c] - 2'd1;
            end
         end else if (taken_EX) begin
            valid_d[wr_idx_c]  = 1'b1;
            tag_d[wr_idx_c]    = wr_tag_c;
            target_d[wr_idx_c] = target_EX;
            ctr_d[wr_idx_c]    = 2'b10;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         target_q   <= target_d;
         ctr_q      <= ctr_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign br_cnt_o   = br_cnt_q;
   assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed test-plan steps plus random training
// traffic, checked against an array-of-ints reference model.
module tb_branch_predictor;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] pc_IF;
   logic        pred_taken_o;
   logic [31:0] pred_pc_o;
   logic        update_en_i;
   logic [31:0] pc_EX;
   logic        taken_EX;
   logic [31:0] target_EX;
   logic        mispredict_i;
   logic [31:0] br_cnt_o;
   logic [31:0] miss_cnt_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: plain per-entry records, counter as an integer 0..3.
   bit          m_valid [64];
   int unsigned m_tag   [64];
   int unsigned m_tgt   [64];
   int          m_ctr   [64];
   int unsigned m_br;
   int unsigned m_miss;

   always #5 clk_i = ~clk_i;

   branch_predictor #(.ENTRIES(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pc_IF(pc_IF),
      .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
      .update_en_i(update_en_i), .pc_EX(pc_EX), .taken_EX(taken_EX),
      .target_EX(target_EX), .mispredict_i(mispredict_i),
      .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_br = 0; m_miss = 0;
   endtask

   function automatic bit m_hit(input int unsigned pc);
      return m_valid[(pc / 4) % 64] && (m_tag[(pc / 4) % 64] == pc / 256);
   endfunction

   function automatic bit m_taken(input int unsigned pc);
      return m_hit(pc) && (m_ctr[(pc / 4) % 64] >= 2);
   endfunction

   function automatic int unsigned m_pred(input int unsigned pc);
      return m_taken(pc) ? m_tgt[(pc / 4) % 64] : pc + 4;
   endfunction

   task automatic model_update(input int unsigned pc, input bit tk, input int unsigned tgt, input bit mp);
      int i;
      i = int'((pc / 4) % 64);
      m_br++;
      if (mp) m_miss++;
      if (m_hit(pc)) begin
         if (tk) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (tk) begin
         m_valid[i] = 1'b1; m_tag[i] = pc / 256; m_tgt[i] = tgt; m_ctr[i] = 2;
      end
   endtask

   // One cycle: drive, check lookup against model, clock, train model, check counters.
   task automatic step(input string tag, input logic [31:0] pif, input bit en,
                       input logic [31:0] pex, input bit tk, input logic [31:0] tgt, input bit mp);
      pc_IF = pif; update_en_i = en; pc_EX = pex; taken_EX = tk; target_EX = tgt; mispredict_i = mp;
      #2;
      chk({tag, "_taken"}, 32'(pred_taken_o), 32'(m_taken(pif)));
      chk({tag, "_pc"}, pred_pc_o, m_pred(pif));
      @(posedge clk_i);
      if (en) model_update(pex, tk, tgt, mp);
      #1;
      chk({tag, "_br"}, br_cnt_o, m_br);
      chk({tag, "_miss"}, miss_cnt_o, m_miss);
   endtask

   task automatic look(input string tag, input logic [31:0] pif, input logic [31:0] exp_pc);
      pc_IF = pif; update_en_i = 1'b0;
      #1;
      chk(tag, pred_pc_o, exp_pc);
      chk({tag, "_model"}, pred_pc_o, m_pred(pif));
   endtask

   initial begin
      logic [31:0] rpc, rtg;
      rst_ni = 1'b0; pc_IF = 32'h100; update_en_i = 1'b0; pc_EX = '0;
      taken_EX = 1'b0; target_EX = '0; mispredict_i = 1'b0;
      model_reset();
      #2;
      chk("rst_taken", 32'(pred_taken_o), 32'd0);
      chk("rst_pc", pred_pc_o, 32'h104);
      chk("rst_br", br_cnt_o, 32'd0);
      chk("rst_miss", miss_cnt_o, 32'd0);
      #5 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      step("alloc", 32'h100, 1, 32'h100, 1, 32'h200, 1);
      look("alloc_hit", 32'h100, 32'h200);
      chk("alloc_cnt", br_cnt_o, 32'd1);
      chk("alloc_mcnt", miss_cnt_o, 32'd1);
      step("dn1", 32'h100, 1, 32'h100, 0, 32'h0, 1);
      look("dn1_pc", 32'h100, 32'h104);
      step("dn2", 32'h100, 1, 32'h100, 0, 32'h0, 0);
      step("dn3", 32'h100, 1, 32'h100, 0, 32'h0, 0);
      step("up1", 32'h100, 1, 32'h100, 1, 32'h200, 0);
      look("up1_pc", 32'h100, 32'h104);
      step("up2", 32'h100, 1, 32'h100, 1, 32'h200, 1);
      look("up2_pc", 32'h100, 32'h200);
      for (int k = 0; k < 4; k++) step("sat", 32'h100, 1, 32'h100, 1, 32'h200, 0);
      step("sat_dn", 32'h100, 1, 32'h100, 0, 32'h0, 1);
      look("sat_dn_pc", 32'h100, 32'h200);
      step("idle", 32'h100, 0, 32'h100, 0, 32'h0, 1);
      look("alias_miss", 32'h200, 32'h204);
      step("alias_rep", 32'h200, 1, 32'h200, 1, 32'h300, 0);
      look("alias_new", 32'h200, 32'h300);
      look("alias_old", 32'h100, 32'h104);
      step("rw_same", 32'h100, 1, 32'h100, 1, 32'h200, 0);
      look("rw_next", 32'h100, 32'h200);

      for (int n = 0; n < 300; n++) begin
         rpc = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom)};
         rtg = $urandom;
         step("rnd", rpc, 1'($urandom_range(0, 3) != 0),
              {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom)},
              1'($urandom), rtg, 1'($urandom));
      end

      pc_IF = 32'h100; update_en_i = 1'b1; pc_EX = 32'h100; taken_EX = 1'b1;
      target_EX = 32'h500; mispredict_i = 1'b1;
      #2 rst_ni = 1'b0;
      model_reset();
      #1;
      chk("arst_taken", 32'(pred_taken_o), 32'd0);
      chk("arst_pc", pred_pc_o, 32'h104);
      chk("arst_br", br_cnt_o, 32'd0);
      chk("arst_miss", miss_cnt_o, 32'd0);
      @(posedge clk_i); #2;
      update_en_i = 1'b0;
      rst_ni = 1'b1;
      #1;
      chk("arst_lost", pred_pc_o, 32'h104);
      step("post", 32'h100, 1, 32'h100, 1, 32'h240, 0);
      look("post_pc", 32'h100, 32'h240);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage 2-bit dynamic branch predictor with a direct-mapped branch target buffer (BTB). It sits directly upstream of the hazard detection unit.
- Each cycle it looks up pc_IF and drives the predicted next fetch PC. That prediction flows down the pipe as pc_ID, and the hazard unit checks it against the resolved EX-stage target.
- When a control-flow instruction resolves in EX, the block trains its counters and targets. It consumes the hazard unit's mispredict flag (comp_o) for statistics.

Parameters:
- ENTRIES, 64, number of BTB/counter entries; power of two, minimum 4.
- IDX_W, $clog2(ENTRIES), index width.
- TAG_W, 30-IDX_W, tag width; the tag is pc[31:IDX_W+2].

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- pc_IF  input  32  current fetch PC.
- pred_taken_o  output  1  lookup hit and predicted taken.
- pred_pc_o  output  32  predicted next fetch PC.
- update_en_i  input  1  valid control-flow instruction in EX (op_ex[6:4]==3'b110, not a bubble).
- pc_EX  input  32  PC of the EX-stage instruction.
- taken_EX  input  1  resolved direction (PCSel_EX).
- target_EX  input  32  resolved target (alu).
- mispredict_i  input  1  hazard unit comp_o for the same EX instruction.
- br_cnt_o  output  32  count of resolved control-flow instructions.
- miss_cnt_o  output  32  count of mispredictions.

Behaviour:
- Storage, per entry: valid (1), tag (TAG_W), target (32), ctr (2). Entries are implemented as flops.
- Index is pc[IDX_W+1:2]; pc[1:0] is ignored.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Reset (rst_ni=0, async):
  - all valid=0, tag=0, target=0, ctr=2'b01;
  - br_cnt_o=0, miss_cnt_o=0.
  - Combinational outputs follow: pred_taken_o=0 and pred_pc_o=pc_IF+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==pc_IF tag bits.
  - pred_taken_o = hit && ctr[idx][1].
  - pred_pc_o = target[idx] when pred_taken_o, else pc_IF+4. Addition wraps modulo 2^32.
- Update (registered, on the rising edge when update_en_i=1, indexed by pc_EX):
  - Hit, taken_EX=1: ctr saturating increment (11 stays 11); target <= target_EX.
  - Hit, taken_EX=0: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken_EX=1: allocate by overwriting the entry. Set valid=1, tag=pc_EX tag, target=target_EX, ctr=2'b10.
  - Miss, taken_EX=0: no change; not-taken branches are never allocated.
  - Jumps (JAL/JALR) arrive with taken_EX=1 and are handled identically.
- update_en_i=0: no table change, including while a stall or flush is active. Gating of bubbles is the upstream control's responsibility.
- Simultaneous lookup and update of the same index: the lookup returns the pre-update contents. There is no write-to-read bypass; the new value is visible from the next cycle.
- Statistics:
  - br_cnt_o increments on each cycle with update_en_i=1.
  - miss_cnt_o increments when update_en_i && mispredict_i.
  - Both wrap from 0xFFFFFFFF to 0.
  - mispredict_i is ignored when update_en_i=0.
- Reset asserted mid-operation clears all state immediately, independent of the clock. An update pending in the same cycle is lost.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset, then pc_IF=0x100 -> pred_taken_o=0, pred_pc_o=0x104, br_cnt_o=0, miss_cnt_o=0.
- Allocation: update_en_i=1, pc_EX=0x100, taken_EX=1, target_EX=0x200, mispredict_i=1.
  - Next cycle with pc_IF=0x100 -> pred_taken_o=1, pred_pc_o=0x200; ctr=10; br_cnt_o=1, miss_cnt_o=1.
- Training down:
  - After the allocation above, one not-taken update at 0x100 -> ctr=01, pred_pc_o=0x104.
  - A second not-taken update -> ctr=00; a third -> ctr stays 00.
  - Two taken updates then restore pred_pc_o=0x200.
- Saturation up: three taken updates at 0x100 -> ctr=11; a fourth -> ctr stays 11. One not-taken update -> ctr=10 and the prediction is still taken.
- Aliasing (ENTRIES=64):
  - Entry for 0x100 is valid. pc_IF=0x200 shares the index, has a different tag -> miss, pred_pc_o=0x204.
  - A taken update at pc_EX=0x200, target_EX=0x300 replaces the entry -> 0x200 predicts 0x300, and 0x100 now misses.
- Same-cycle read/write: pc_IF=pc_EX=0x100 with an allocating update -> pred_pc_o=0x104 in that cycle and 0x200 the next cycle.
- Async reset: assert rst_ni mid-cycle after training -> outputs return to reset values before the next edge.
